// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 8680;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with framing/overrun flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_i,
  input  logic                   rd_en_i,
  output logic [7:0]             data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   parity_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t HALF_BIT = cnt_t'(CLKS_PER_BIT/2 - 1);
  localparam cnt_t LAST_CNT = cnt_t'(CLKS_PER_BIT - 1);

  logic      rx_meta_q, rx_s_q;
  rx_state_t state_q;
  cnt_t      cnt_q;
  logic [2:0] idx_q;
  byte_t     shift_q;
  logic      frame_err_q, overrun_q;
  logic      par_bad_q;
  logic      stop_tick, push, fifo_full;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign parity_err_o = par_err_q;
`else
  assign par_bad_q    = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  // The push is decided on the stop-sample cycle itself so the byte lands
  // in the FIFO on that edge.
  assign stop_tick = (state_q == STOP) && (cnt_q == LAST_CNT);
  assign push      = stop_tick && rx_s_q && !par_bad_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_BIT) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s_q ^ (^shift_q);
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_bad_q;
`endif
            if (rx_s_q) begin
              state_q   <= IDLE;
              overrun_q <= !par_bad_q && fifo_full && !rd_en_i;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must return high before a new start is trusted.
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd_en_i),
    .rdata_o (data_o),
    .empty_o (empty_o),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  assign full_o = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus a randomized
// phase checked against a queue model of the receive FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 171;
`else
  localparam int STOP_EDGE = 155;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, rd_en;
  logic [7:0] data;
  logic       empty, full, fe, ov, pe;
  logic [2:0] count;

  int n_chk = 0, n_err = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0;
  byte unsigned model_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .rd_en_i(rd_en),
    .data_o(data), .empty_o(empty), .full_o(full), .count_o(count),
    .frame_err_o(fe), .overrun_o(ov), .parity_err_o(pe)
  );

  always @(negedge clk) begin
    if (!rst) begin
      fe_n += int'(fe);
      ov_n += int'(ov);
      pe_n += int'(pe);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    if (!stop_bit) repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input int exp);
    @(negedge clk);
    chk(tag, int'(data), exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int ov0, fe0;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_pulses", int'({fe, ov, pe}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, exact push latency, then pop to empty
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 chk("a5_empty_before", int'(empty), 1);
        @(posedge clk);
        #1 chk("a5_empty_after", int'(empty), 0);
        chk("a5_data", int'(data), 8'hA5);
        chk("a5_count", int'(count), 1);
      end
    join
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty_end", int'(empty), 1);
    chk("a5_data_end", int'(data), 0);

    // Short glitch on the idle line
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", int'(count), 0);
    chk("glitch_errs", fe_n + ov_n + pe_n, 0);

    // Framing error with held-low line, then a clean frame
    send(8'h3C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("fe_pulses", fe_n, 1);
    chk("fe_count", int'(count), 0);
    send(8'h5A, 1'b1, 1'b0);
    chk("after_fe_count", int'(count), 1);
    pop_chk("after_fe_data", 8'h5A);

    // Fill then overrun
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    ov0 = ov_n;
    send(8'h05, 1'b1, 1'b0);
    chk("ovr_pulses", ov_n - ov0, 1);
    chk("ovr_count", int'(count), 4);
    for (int i = 1; i <= 4; i++) pop_chk("ovr_drain", i);
    chk("ovr_empty", int'(empty), 1);

    // Full FIFO with a pop on the stop-sample cycle
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    ov0 = ov_n;
    fork
      send(8'h05, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
      end
    join
    chk("pp_overrun", ov_n - ov0, 0);
    chk("pp_count", int'(count), 4);
    for (int i = 2; i <= 5; i++) pop_chk("pp_drain", i);

    // Reset in the middle of bit 4
    fe0 = fe_n;
    @(negedge clk); rx = 1'b0;
    repeat (CPB * 5 + CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB * 12) @(negedge clk);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_fe", fe_n - fe0, 0);
    send(8'hC3, 1'b1, 1'b0);
    chk("c3_count", int'(count), 1);
    pop_chk("c3_data", 8'hC3);
`ifdef UART_RX_PARITY_EN
    send(8'hC3, 1'b1, 1'b1);
    chk("par_pulse", pe_n, 1);
    chk("par_count", int'(count), 0);
`endif

    // Randomized frames and reads against the queue model
    ov0 = ov_n;
    begin
      int exp_ov = 0;
      for (int f = 0; f < 14; f++) begin
        logic [7:0] b = 8'($urandom);
        int k = $urandom_range(0, 2);
        send(b, 1'b1, 1'b0);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ov++;
        chk("rnd_count", int'(count), model_q.size());
        chk("rnd_full", int'(full), int'(model_q.size() == DEPTH));
        for (int r = 0; r < k && model_q.size() > 0; r++)
          pop_chk("rnd_pop", model_q.pop_front());
      end
      while (model_q.size() > 0) pop_chk("rnd_drain", model_q.pop_front());
      chk("rnd_overruns", ov_n - ov0, exp_ov);
      chk("rnd_empty", int'(empty), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side stage consuming the raw serial line and producing buffered bytes for a downstream consumer (LED register, CPU bus slave or loopback transmitter).
- Synchronizes rx_i, detects and validates the start bit, samples at mid-bit, and checks the stop bit.
- Pushes good bytes into a first-word-fall-through FIFO with a read-enable interface.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 8680, clock cycles per bit period (must be >= 4).
- DEPTH, 16, FIFO entries (power of two, >= 2).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  asynchronous serial line, idle high, 8N1, LSB first.
- rd_en_i  input  1  pop head entry; ignored when empty_o=1.
- data_o  output  8  FIFO head byte (FWFT); 8'h00 when empty.
- empty_o  output  1  FIFO empty.
- full_o  output  1  FIFO full.
- count_o  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: good byte dropped because FIFO full.
- parity_err_o  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): two-flop synchronizer flops = 1, FSM = IDLE, bit counter = 0, FIFO pointers = 0. Outputs after reset: empty_o=1, full_o=0, count_o=0, data_o=8'h00, all error pulses 0. Reset mid-frame abandons the frame and does not push it.
- rx_s is rx_i after two flops; all decisions use rx_s.
- IDLE: rx_s=0 -> START, baud counter cleared.
- START: at baud count CLKS_PER_BIT/2-1, sample rx_s.
  - 0 -> DATA, counter cleared, bit index 0.
  - 1 -> IDLE (glitch rejected, no error).
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx] (LSB first). After idx 7 -> STOP (or PARITY when the feature is enabled).
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - 1 -> push attempt, then IDLE.
  - 0 -> frame_err_o pulse, byte discarded, -> BREAK.
- BREAK: wait until rx_s=1, then IDLE. No start detection happens in BREAK.
- Push attempt on the stop-sample cycle:
  - not full -> written; empty_o falls and data_o/count_o update on the next cycle.
  - full and rd_en_i=0 that cycle -> byte dropped, overrun_o pulses the next cycle.
  - full and rd_en_i=1 same cycle -> pop and push both occur; count unchanged, no overrun.
- Pop: rd_en_i & !empty_o advances the read pointer; data_o shows the next entry the following cycle. rd_en_i when empty: no effect, no error.
- Simultaneous push and pop when not full or empty: count unchanged.
- Pointers wrap modulo DEPTH. full_o = (count == DEPTH).
- Latency: stop-bit mid-sample to empty_o low is 1 cycle. rx_i falling edge to start detection is 2-3 cycles (synchronizer).
- Sample points are effectively mid-bit; drift tolerance is about ±4% of the baud rate.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, sampling one even-parity bit CLKS_PER_BIT after bit 7; STOP follows.
  - Mismatch -> parity_err_o pulses on the stop-sample cycle and the byte is discarded (not pushed, no overrun). The frame-check path is otherwise unchanged.
  - If parity and stop both fail, both pulses assert.
- Undefined: 8N1 only; parity_err_o tied 0.

Decomposition:
- Shared package uart_pkg: state enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}, constant DEFAULT_CLKS_PER_BIT = 8680, typedef byte_t = logic [7:0].
- One sub-module sync_fifo (parameters WIDTH, DEPTH; FWFT; push/pop/full/empty/count).
- uart_rx_fifo holds the synchronizer, baud counter and FSM, and instantiates sync_fifo.

Test Plan (bench uses CLKS_PER_BIT=16, DEPTH=4):
- Send 8'hA5 8N1 at 16 clk/bit -> empty_o falls 1 cycle after the stop-bit sample, data_o=8'hA5, count_o=1; one rd_en_i pulse -> empty_o=1, data_o=8'h00.
- 3-cycle low glitch on idle line -> no push, no error, FSM back in IDLE.
- Send 8'h3C with stop bit held low, line low 40 more cycles, then high -> frame_err_o one pulse, count_o=0; a following 8'h5A is received correctly.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no reads -> full_o=1 after the 4th byte, overrun_o pulses on the 5th. Reading out yields 01,02,03,04.
- FIFO full, rd_en_i asserted exactly on the 5th byte's stop-sample cycle -> no overrun, count_o stays 4, final contents 02,03,04,05.
- Assert rst_i during bit 4 of a frame, then send 8'hC3 -> the aborted frame is not pushed; 8'hC3 is received. With UART_RX_PARITY_EN, 8'hC3 sent with parity bit 1 -> parity_err_o pulses, count_o=0.
